// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared I2C slave definitions: transmitter state encoding and
//             bus-level constants for ACK/NACK and SDA release.
//  Revision : 1.0  initial release
// ============================================================================
package i2c_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    ACK    = 3'd3,
    DECIDE = 3'd4
  } tx_state_t;

  // Bus levels seen/driven on SDA
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic SDA_RELEASE = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_tx_shifter
//  Purpose  : Parallel-load shift register for the I2C transmitter. Presents
//             the bit that will be on the wire after this clock's load/shift,
//             so the caller can register it into SDA in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_tx_shifter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  bit_next
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_data_next;

  // Shift direction and tap position follow the configured bit order
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = r_data << 1;
      assign bit_next  = w_data_next[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = r_data >> 1;
      assign bit_next  = w_data_next[0];
    end
  endgenerate

  // Load takes priority over shift; otherwise hold
  always_comb begin
    w_data_next = r_data;
    if (load) begin
      w_data_next = load_data;
    end else if (shift) begin
      w_data_next = w_shifted;
    end
  end

  // Shift register storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '1;
    end else begin
      r_data <= w_data_next;
    end
  end

endmodule : i2c_tx_shifter
`default_nettype wire

// File: rtl/i2c_slave_tx_stream.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_tx_stream
//  Purpose  : Multi-word I2C slave transmitter for master-read transfers.
//             Pulls words from a valid/ready source, shifts them onto SDA on
//             SCL falling edges, samples the master ACK/NACK after each word
//             and ends on NACK, word limit, or abort.
//  Config   : I2C_SLAVE_TX_CLOCK_STRETCH_EN - stretch SCL on source underrun
//             instead of sending FILL_VALUE.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_tx_stream
  import i2c_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter bit                     MSB_FIRST   = 1'b1,
  parameter logic [DATA_WIDTH-1:0]  FILL_VALUE  = {DATA_WIDTH{1'b1}},
  parameter int unsigned            COUNT_WIDTH = 8,
  parameter logic [COUNT_WIDTH-1:0] MAX_WORDS   = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   abort,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda,
  output logic                   scl_hold,
  output logic                   word_done,
  output logic                   nack,
  output logic                   underrun,
  output logic                   finish,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned           BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_t              r_state, w_state_nx;
  logic                   r_scl_last;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nx;
  logic                   r_sda, w_sda_nx;
  logic                   r_word_done, w_word_done_nx;
  logic                   r_nack, w_nack_nx;
  logic                   r_finish, w_finish_nx;
  logic                   r_underrun, w_underrun_nx;
  logic [COUNT_WIDTH-1:0] r_word_count, w_word_count_nx;
  logic                   r_ack_bit, w_ack_bit_nx;
  logic                   w_load, w_shift, w_bit_next;
  logic [DATA_WIDTH-1:0]  w_load_data;
  logic                   w_fall, w_rise;
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
  logic                   r_scl_hold, w_scl_hold_nx;
`endif

  assign w_fall = r_scl_last & ~scl;
  assign w_rise = ~r_scl_last & scl;

  i2c_tx_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (w_load),
    .shift     (w_shift),
    .load_data (w_load_data),
    .bit_next  (w_bit_next)
  );

  // Next-state, datapath control and output decode; abort overrides everything
  always_comb begin
    w_state_nx      = r_state;
    w_bit_cnt_nx    = r_bit_cnt;
    w_sda_nx        = r_sda;
    w_word_done_nx  = 1'b0;
    w_nack_nx       = 1'b0;
    w_finish_nx     = 1'b0;
    w_underrun_nx   = r_underrun;
    w_word_count_nx = r_word_count;
    w_ack_bit_nx    = r_ack_bit;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_load_data     = tx_data;
    tx_ready        = 1'b0;
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
    w_scl_hold_nx   = 1'b0;
`endif
    if (abort) begin
      w_state_nx = IDLE;
      w_sda_nx   = SDA_RELEASE;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            w_word_count_nx = '0;
            w_underrun_nx   = 1'b0;
            w_state_nx      = LOAD;
          end
        end
        LOAD: begin
          if (tx_valid) begin
            w_load       = 1'b1;
            tx_ready     = 1'b1;
            w_sda_nx     = w_bit_next;
            w_bit_cnt_nx = '0;
            w_state_nx   = SHIFT;
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
            // keep SCL held one more clock so SDA settles before release
            w_scl_hold_nx = r_scl_hold;
`endif
          end else begin
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
            w_scl_hold_nx = 1'b1;
`else
            w_load        = 1'b1;
            w_load_data   = FILL_VALUE;
            w_underrun_nx = 1'b1;
            w_sda_nx      = w_bit_next;
            w_bit_cnt_nx  = '0;
            w_state_nx    = SHIFT;
`endif
          end
        end
        SHIFT: begin
          if (w_fall) begin
            if (r_bit_cnt == LAST_BIT) begin
              w_sda_nx   = SDA_RELEASE;
              w_state_nx = ACK;
            end else begin
              w_bit_cnt_nx = r_bit_cnt + BIT_CNT_W'(1);
              w_shift      = 1'b1;
              w_sda_nx     = w_bit_next;
            end
          end
        end
        ACK: begin
          if (w_rise) begin
            w_ack_bit_nx   = sda_in;
            w_nack_nx      = (sda_in != I2C_ACK);
            w_word_done_nx = 1'b1;
            if (r_word_count != '1) begin
              w_word_count_nx = r_word_count + COUNT_WIDTH'(1);
            end
            w_state_nx = DECIDE;
          end
        end
        DECIDE: begin
          if (w_fall) begin
            if ((r_ack_bit == I2C_NACK) ||
                ((MAX_WORDS != '0) && (r_word_count == MAX_WORDS))) begin
              w_finish_nx = 1'b1;
              w_sda_nx    = SDA_RELEASE;
              w_state_nx  = IDLE;
            end else begin
              w_state_nx = LOAD;
            end
          end
        end
        default: begin
          w_sda_nx   = SDA_RELEASE;
          w_state_nx = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_scl_last   <= 1'b1;
      r_bit_cnt    <= '0;
      r_sda        <= SDA_RELEASE;
      r_word_done  <= 1'b0;
      r_nack       <= 1'b0;
      r_finish     <= 1'b0;
      r_underrun   <= 1'b0;
      r_word_count <= '0;
      r_ack_bit    <= 1'b0;
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
      r_scl_hold   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_scl_last   <= scl;
      r_bit_cnt    <= w_bit_cnt_nx;
      r_sda        <= w_sda_nx;
      r_word_done  <= w_word_done_nx;
      r_nack       <= w_nack_nx;
      r_finish     <= w_finish_nx;
      r_underrun   <= w_underrun_nx;
      r_word_count <= w_word_count_nx;
      r_ack_bit    <= w_ack_bit_nx;
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
      r_scl_hold   <= w_scl_hold_nx;
`endif
    end
  end

`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
  assign scl_hold = r_scl_hold;
`else
  assign scl_hold = 1'b0;
`endif

  assign sda        = r_sda;
  assign word_done  = r_word_done;
  assign nack       = r_nack;
  assign finish     = r_finish;
  assign underrun   = r_underrun;
  assign word_count = r_word_count;
  assign busy       = (r_state != IDLE);

endmodule : i2c_slave_tx_stream
`default_nettype wire

// File: tb/tb_i2c_slave_tx_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_i2c_slave_tx_stream
//  Purpose  : Self-checking bench. Instance A: 8-bit MSB-first, unlimited.
//             Instance B: 16-bit LSB-first, MAX_WORDS=3. A bus-level master
//             model clocks SCL and reads SDA; expected bit streams are queued
//             when words are offered and popped as the master reads them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_tx_stream;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        abort = 1'b0;
  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic [7:0]  tx_data_a = 8'h00;
  logic [15:0] tx_data_b = 16'h0000;
  logic        tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic        tx_ready_a, tx_ready_b;
  logic        sda_a, sda_b, sda_in;
  logic        scl_hold_a, scl_hold_b;
  logic        word_done_a, word_done_b, nack_a, nack_b;
  logic        underrun_a, underrun_b, finish_a, finish_b, busy_a, busy_b;
  logic [7:0]  word_count_a, word_count_b;

  assign sda_in = m_sda & sda_a & sda_b;

  i2c_slave_tx_stream dut_a (
    .clock(clk), .reset_n(reset_n), .enable(enable_a), .abort(abort),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .scl(scl), .sda_in(sda_in), .sda(sda_a), .scl_hold(scl_hold_a),
    .word_done(word_done_a), .nack(nack_a), .underrun(underrun_a),
    .finish(finish_a), .busy(busy_a), .word_count(word_count_a)
  );

  i2c_slave_tx_stream #(
    .DATA_WIDTH(16), .MSB_FIRST(1'b0), .MAX_WORDS(8'd3)
  ) dut_b (
    .clock(clk), .reset_n(reset_n), .enable(enable_b), .abort(abort),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .scl(scl), .sda_in(sda_in), .sda(sda_b), .scl_hold(scl_hold_b),
    .word_done(word_done_b), .nack(nack_b), .underrun(underrun_b),
    .finish(finish_b), .busy(busy_b), .word_count(word_count_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] src_a[$], src_b[$], exp_a[$], exp_b[$];
  bit          nackq_a[$], nackq_b[$];
  int          rdy_a = 0, rdy_b = 0, fin_a = 0, fin_b = 0;
  int          unstable = 0, timeouts = 0;
  bit          saw_hold = 0;
  bit          take_a, take_b;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Source A: handshake seen at negedge, queue advanced after the next posedge
  always begin
    logic [15:0] head;
    @(negedge clk);
    take_a = tx_ready_a;
    @(posedge clk);
    #2;
    if (take_a) begin
      rdy_a++;
      if (src_a.size() > 0) void'(src_a.pop_front());
    end
    tx_valid_a = (src_a.size() != 0);
    head = (src_a.size() != 0) ? src_a[0] : 16'h0000;
    tx_data_a = head[7:0];
  end

  // Source B
  always begin
    @(negedge clk);
    take_b = tx_ready_b;
    @(posedge clk);
    #2;
    if (take_b) begin
      rdy_b++;
      if (src_b.size() > 0) void'(src_b.pop_front());
    end
    tx_valid_b = (src_b.size() != 0);
    tx_data_b  = (src_b.size() != 0) ? src_b[0] : 16'h0000;
  end

  // Event monitor
  always @(negedge clk) begin
    if (word_done_a) nackq_a.push_back(nack_a);
    if (word_done_b) nackq_b.push_back(nack_b);
    if (finish_a) fin_a++;
    if (finish_b) fin_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    rdy_a = 0; rdy_b = 0; fin_a = 0; fin_b = 0;
    nackq_a.delete(); nackq_b.delete();
    unstable = 0; timeouts = 0; saw_hold = 0;
  endtask

  // One SCL pulse; entered and left just after a falling edge
  task automatic m_bit(input bit sel, output bit b);
    int n;
    bit b0;
    repeat (6) tick();
    n = 0;
    while (((sel ? scl_hold_b : scl_hold_a) == 1'b1) && n < 400) begin
      saw_hold = 1;
      tick();
      n++;
    end
    if (n >= 400) timeouts++;
    scl = 1'b1;
    repeat (3) tick();
    b0 = sel ? sda_b : sda_a;
    repeat (3) tick();
    b = sel ? sda_b : sda_a;
    if (b != b0) unstable++;
    scl = 1'b0;
  endtask

  // Read one word plus the ACK slot; bits collected first-received-in-MSB
  task automatic m_word(input bit sel, input int width, input bit ack_val,
                        output logic [15:0] got);
    bit b;
    got = '0;
    for (int i = 0; i < width; i++) begin
      m_bit(sel, b);
      got = {got[14:0], b};
    end
    m_sda = ack_val;
    m_bit(sel, b);
    m_sda = 1'b1;
  endtask

  // Address-ACK fall with the start pulse
  task automatic start(input bit sel);
    scl = 1'b1;
    repeat (4) tick();
    scl = 1'b0;
    if (sel) enable_b = 1'b1; else enable_a = 1'b1;
    tick();
    enable_a = 1'b0;
    enable_b = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({sda_a, scl_hold_a, tx_ready_a, word_done_a, nack_a, finish_a, underrun_a, busy_a} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs_a got %b required 10000000",
               {sda_a, scl_hold_a, tx_ready_a, word_done_a, nack_a, finish_a, underrun_a, busy_a});
    end
    vectors++;
    if (word_count_a !== 8'd0) begin
      errors++; $display("FAIL reset_count_a got %0d required 0", word_count_a);
    end
    vectors++;
    if ({sda_b, scl_hold_b, tx_ready_b, word_done_b, nack_b, finish_b, underrun_b, busy_b} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs_b got %b required 10000000",
               {sda_b, scl_hold_b, tx_ready_b, word_done_b, nack_b, finish_b, underrun_b, busy_b});
    end
    vectors++;
    if (word_count_b !== 8'd0) begin
      errors++; $display("FAIL reset_count_b got %0d required 0", word_count_b);
    end
  endtask

  task automatic test_basic();
    logic [15:0] got, exp;
    logic [7:0] words [2] = '{8'hA5, 8'h3C};
    clear_counters();
    foreach (words[i]) begin
      src_a.push_back({8'h00, words[i]});
      exp_a.push_back({8'h00, words[i]});
    end
    start(0);
    for (int i = 0; i < 2; i++) begin
      m_word(0, 8, (i == 1), got);
      vectors++;
      exp = (exp_a.size() != 0) ? exp_a.pop_front() : 16'hxxxx;
      if (got !== exp) begin
        errors++; $display("FAIL basic_word%0d got %h required %h", i, got, exp);
      end
    end
    repeat (3) tick();
    vectors++;
    if (rdy_a != 2) begin errors++; $display("FAIL basic_tx_ready got %0d required 2", rdy_a); end
    vectors++;
    if (nackq_a.size() != 2 || nackq_a[0] !== 1'b0 || nackq_a[1] !== 1'b1) begin
      errors++; $display("FAIL basic_nack_seq got %0d samples required 2 (0,1)", nackq_a.size());
    end
    vectors++;
    if (fin_a != 1) begin errors++; $display("FAIL basic_finish got %0d required 1", fin_a); end
    vectors++;
    if (word_count_a !== 8'd2) begin errors++; $display("FAIL basic_count got %0d required 2", word_count_a); end
    vectors++;
    if ({busy_a, underrun_a} !== 2'b00) begin
      errors++; $display("FAIL basic_busy_underrun got %b required 00", {busy_a, underrun_a});
    end
    vectors++;
    if (unstable != 0) begin errors++; $display("FAIL basic_sda_stable got %0d changes required 0", unstable); end
  endtask

  task automatic test_lsb16_max();
    logic [15:0] got, exp;
    logic [15:0] words [4] = '{16'h8001, 16'h1234, 16'hBEEF, 16'h0F0F};
    clear_counters();
    foreach (words[i]) begin
      src_b.push_back(words[i]);
      exp_b.push_back(rev16(words[i]));
    end
    start(1);
    for (int i = 0; i < 3; i++) begin
      m_word(1, 16, 1'b0, got);
      vectors++;
      exp = (exp_b.size() != 0) ? exp_b.pop_front() : 16'hxxxx;
      if (got !== exp) begin
        errors++; $display("FAIL lsb16_word%0d got %h required %h", i, got, exp);
      end
    end
    repeat (3) tick();
    vectors++;
    if (rdy_b != 3) begin errors++; $display("FAIL max_tx_ready got %0d required 3", rdy_b); end
    vectors++;
    if (fin_b != 1) begin errors++; $display("FAIL max_finish got %0d required 1", fin_b); end
    vectors++;
    if (word_count_b !== 8'd3) begin errors++; $display("FAIL max_count got %0d required 3", word_count_b); end
    vectors++;
    if (src_b.size() != 1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL max_leftover got %0d words busy %b required 1 words busy 0", src_b.size(), busy_b);
    end
    vectors++;
    if (nackq_b.size() != 3 || nackq_b[0] || nackq_b[1] || nackq_b[2]) begin
      errors++; $display("FAIL max_ack_seq got %0d samples required 3 ACKs", nackq_b.size());
    end
    src_b.delete();
    exp_b.delete();
  endtask

  task automatic test_underrun();
    logic [15:0] got, exp;
    clear_counters();
    src_a.push_back(16'h005A);
    exp_a.push_back(16'h005A);
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
    exp_a.push_back(16'h00C3);
`else
    exp_a.push_back(16'h00FF);
`endif
    start(0);
    m_word(0, 8, 1'b0, got);
    vectors++;
    exp = (exp_a.size() != 0) ? exp_a.pop_front() : 16'hxxxx;
    if (got !== exp) begin errors++; $display("FAIL underrun_word0 got %h required %h", got, exp); end
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
    fork
      begin
        repeat (40) tick();
        src_a.push_back(16'h00C3);
      end
    join_none
`endif
    m_word(0, 8, 1'b1, got);
    vectors++;
    exp = (exp_a.size() != 0) ? exp_a.pop_front() : 16'hxxxx;
    if (got !== exp) begin errors++; $display("FAIL underrun_word1 got %h required %h", got, exp); end
    repeat (3) tick();
`ifdef I2C_SLAVE_TX_CLOCK_STRETCH_EN
    vectors++;
    if ({saw_hold, underrun_a} !== 2'b10) begin
      errors++; $display("FAIL stretch_hold_underrun got %b required 10", {saw_hold, underrun_a});
    end
    vectors++;
    if (rdy_a != 2) begin errors++; $display("FAIL stretch_tx_ready got %0d required 2", rdy_a); end
`else
    vectors++;
    if (underrun_a !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b required 1", underrun_a); end
    vectors++;
    if (rdy_a != 1) begin errors++; $display("FAIL underrun_tx_ready got %0d required 1", rdy_a); end
`endif
    vectors++;
    if (fin_a != 1 || word_count_a !== 8'd2) begin
      errors++; $display("FAIL underrun_end got finish %0d count %0d required 1 and 2", fin_a, word_count_a);
    end
    vectors++;
    if (timeouts != 0 || unstable != 0) begin
      errors++; $display("FAIL underrun_bus got timeouts %0d unstable %0d required 0 0", timeouts, unstable);
    end
  endtask

  task automatic test_abort();
    logic [15:0] got, exp;
    bit b;
    clear_counters();
    src_a.push_back(16'h0055);
    start(0);
    vectors++;
    if ({word_count_a, underrun_a} !== 9'd0) begin
      errors++; $display("FAIL abort_enable_clears got count %0d underrun %b required 0 0", word_count_a, underrun_a);
    end
    // Clock out bits 7..4 of 8'h55; bit 3 (a 0) is then on the wire
    for (int i = 0; i < 4; i++) m_bit(0, b);
    repeat (2) tick();
    vectors++;
    if (sda_a !== 1'b0) begin errors++; $display("FAIL abort_pre_sda got %b required 0", sda_a); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({sda_a, busy_a} !== 2'b10) begin
      errors++; $display("FAIL abort_idle got sda %b busy %b required 1 0", sda_a, busy_a);
    end
    repeat (20) tick();
    vectors++;
    if (fin_a != 0 || rdy_a != 1) begin
      errors++; $display("FAIL abort_no_finish got finish %0d tx_ready %0d required 0 1", fin_a, rdy_a);
    end
    // enable coinciding with abort must not start a transfer
    scl = 1'b1;
    repeat (4) tick();
    scl = 1'b0; enable_a = 1'b1; abort = 1'b1;
    tick();
    enable_a = 1'b0; abort = 1'b0;
    tick();
    vectors++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_enable_ignored got busy %b required 0", busy_a); end
    clear_counters();
    src_a.push_back(16'h0066);
    exp_a.push_back(16'h0066);
    start(0);
    m_word(0, 8, 1'b1, got);
    vectors++;
    exp = (exp_a.size() != 0) ? exp_a.pop_front() : 16'hxxxx;
    if (got !== exp) begin errors++; $display("FAIL restart_word got %h required %h", got, exp); end
    repeat (3) tick();
    vectors++;
    if (word_count_a !== 8'd1 || fin_a != 1) begin
      errors++; $display("FAIL restart_end got count %0d finish %0d required 1 1", word_count_a, fin_a);
    end
  endtask

  task automatic test_async_reset();
    bit b;
    clear_counters();
    src_a.push_back(16'h0000);
    start(0);
    m_bit(0, b);
    m_bit(0, b);
    repeat (2) tick();
    vectors++;
    if ({busy_a, sda_a} !== 2'b10) begin
      errors++; $display("FAIL areset_pre got busy %b sda %b required 1 0", busy_a, sda_a);
    end
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({sda_a, scl_hold_a, tx_ready_a, word_done_a, nack_a, finish_a, underrun_a, busy_a} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL areset_outputs got %b required 10000000",
               {sda_a, scl_hold_a, tx_ready_a, word_done_a, nack_a, finish_a, underrun_a, busy_a});
    end
    vectors++;
    if (word_count_a !== 8'd0) begin errors++; $display("FAIL areset_count got %0d required 0", word_count_a); end
    #2 reset_n = 1'b1;
    scl = 1'b1;
    repeat (3) tick();
    vectors++;
    if ({sda_a, busy_a} !== 2'b10) begin
      errors++; $display("FAIL areset_post got sda %b busy %b required 1 0", sda_a, busy_a);
    end
    src_a.delete();
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    test_reset();
    test_basic();
    test_lsb16_max();
    test_underrun();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog got timeout required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_i2c_slave_tx_stream
`default_nettype wire
